gc2bin_arb: RTL
===============

GC2BIN_ARB -- requirements
Module: gc2bin_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, the Gray-code and binary word width (≥2).
REQ-002 SHALL have parameter NUM_REQ, fixed at 4, the number of requesters; ID width is 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port en, input, 1, arbitration enable; low blocks new accepts.
REQ-006 SHALL have port bypass, input, 1; high passes Gray words through unconverted.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester word-valid.
REQ-008 SHALL have port req_gc, input, NUM_REQ*DATA_WIDTH, Gray words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_ready, output, NUM_REQ, per-requester accept strobe.
REQ-010 SHALL have port out_valid, output, 1, output register holds a result.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have port out_bin, output, DATA_WIDTH, converted (or bypassed) word.
REQ-013 SHALL have port out_id, output, 2, index of the requester that supplied out_bin.
REQ-014 SHALL have port accept_cnt, output, 16, total accepted-word count.

Function
REQ-015 SHALL share one Gray-to-binary converter among the 4 requesters: bin[k] = XOR of gc[DATA_WIDTH-1:k].
REQ-016 SHALL grant the valid requester first at or after rr_ptr in cyclic order 0,1,2,3,0; grant is combinational on req_valid, rr_ptr, en and output-register state.
REQ-017 SHALL assert at most one req_ready bit per cycle, only for the granted requester, and only when en=1 and (out_valid=0 or out_ready=1).
REQ-018 SHALL define an accept as req_valid[i] & req_ready[i] in the same cycle.
REQ-019 On accept from requester g, SHALL set rr_ptr to (g+1) mod 4 at the next edge; without an accept rr_ptr SHALL hold.
REQ-020 On accept, SHALL load out_bin (converted, or raw if bypass=1 in the accept cycle), out_id=g and out_valid=1 at the next edge; latency 1 cycle.
REQ-021 On out_valid & out_ready without a new accept, SHALL clear out_valid at the next edge; out_bin and out_id hold their last values.
REQ-022 On simultaneous drain and accept, SHALL replace the output register with the new word and keep out_valid=1, sustaining one word per cycle.
REQ-023 While out_valid=1 and out_ready=0, SHALL hold out_bin, out_id and out_valid stable and deassert all req_ready.
REQ-024 SHALL keep a two-state FSM: IDLE (out_valid=0) and FULL (out_valid=1); IDLE->FULL on accept; FULL->IDLE on drain without accept; otherwise hold.
REQ-025 Deasserting en SHALL stop new accepts only; a held result SHALL still drain normally.
REQ-026 SHALL increment accept_cnt by 1 per accept, wrapping 0xFFFF->0x0000 without a flag.
REQ-027 With req_valid=0, SHALL grant nothing and leave rr_ptr unchanged.

Reset
REQ-028 On rst_n low, SHALL immediately force out_valid=0, out_bin=0, out_id=0, rr_ptr=0, accept_cnt=0 and FSM=IDLE; req_ready SHALL be 0 while rst_n is low.
REQ-029 Reset asserted mid-transfer SHALL discard the held result; no word SHALL be output after release without a new accept.
REQ-030 SHALL treat rst_n release as synchronous to clk; first accept possible on the first edge after release.

Verification
REQ-031 Scenario: reset release, en=1, out_ready=1, only req 2 valid with gc=4'b0110 -> one cycle later out_valid=1, out_bin=4'b0100, out_id=2, accept_cnt=1.
REQ-032 Scenario: all 4 valid continuously, out_ready=1 -> grants cycle 0,1,2,3,0; one result per cycle; out_id matches.
REQ-033 Scenario: out_ready=0 for 3 cycles with out_valid=1 -> req_ready all 0, output stable; out_ready=1 -> drain plus new accept in the same cycle.
REQ-034 Scenario: bypass=1, gc=4'b1011 -> out_bin=4'b1011; bypass=0, same gc -> out_bin=4'b1101.
REQ-035 Scenario: en=0 with requests pending and one result held -> held result drains, no accepts, accept_cnt unchanged.
REQ-036 Scenario: rst_n low while out_valid=1 and accept_cnt=0xFFFF -> all outputs 0 immediately; separately, without reset, 0xFFFF plus one accept -> 0x0000.

Source files
------------

// File: rtl/gc2bin_arb.sv
// gc2bin_arb: round-robin arbiter feeding one shared Gray-to-binary converter into a one-word output register
module gc2bin_arb #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          bypass,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_gc,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_bin,
    output logic [1:0]                    out_id,
    output logic [15:0]                   accept_cnt
);
    typedef enum logic {IDLE, FULL} state_t;
    state_t state, state_nxt;
    logic [1:0] rr_ptr, grant;
    logic found, can_take, accept;
    logic [DATA_WIDTH-1:0] sel_gc, conv;

    // first valid requester at or after rr_ptr, wrapping 3 -> 0
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[rr_ptr + k[1:0]]) begin
                grant = rr_ptr + k[1:0];
                found = 1'b1;
            end
        end
    end

    assign out_valid = (state == FULL);
    assign can_take  = rst_n & en & (!out_valid | out_ready);
    assign accept    = can_take & found;
    assign req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant) : '0;
    assign sel_gc    = req_gc[grant*DATA_WIDTH +: DATA_WIDTH];

    // shared converter: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        conv = '0;
        for (int k = 0; k < DATA_WIDTH; k++) conv[k] = ^(sel_gc >> k);
    end

    // output-register occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // an accept always fills the register; a drain without an accept empties it
    always_comb begin
        state_nxt = state;
        if (accept)                      state_nxt = FULL;
        else if (out_valid && out_ready) state_nxt = IDLE;
    end

    // capture the granted word, advance the pointer and count accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bin    <= '0;
            out_id     <= '0;
            rr_ptr     <= '0;
            accept_cnt <= '0;
        end else if (accept) begin
            out_bin    <= bypass ? sel_gc : conv;
            out_id     <= grant;
            rr_ptr     <= grant + 2'd1;
            accept_cnt <= accept_cnt + 16'd1;
        end
    end
endmodule
